// File: rtl/fifo_req_ctrl.sv
// fifo_req_ctrl
// -----------------------------------------------------------------------------
// Request side of the queue. Raw push-button levels (write, read, read-more)
// are synchronized and edge-detected, then turned into single-cycle FIFO
// write/read strobes by a small FSM. Read-more presses run a multi-word read
// burst with a configurable idle gap between reads. Every word read from the
// FIFO is captured into rd_data_q for display.
//
// Optional feature: define FIFO_BTN_DEBOUNCE_EN to insert a per-button
// stability counter (DB_CYCLES) after each synchronizer. Without the macro
// the synchronized level feeds the edge detector directly.
//
// Parameters:
//   DATA_W     FIFO data width
//   BURST_LEN  maximum words per read-more burst (1..15)
//   GAP        idle cycles between burst reads (0..15)
//   DB_CYCLES  debounce stability count (only with FIFO_BTN_DEBOUNCE_EN)
//
// Ports:
//   clk            system clock, rising edge
//   rst_edge       synchronous active-high reset
//   wr_btn         raw write request (asynchronous level)
//   rd_btn         raw read request (asynchronous level)
//   rm_btn         raw read-more request (asynchronous level)
//   fifo_full      FIFO full flag
//   fifo_empty     FIFO empty flag
//   fifo_rd_data   FIFO read data, valid one cycle after fifo_rd
//   fifo_we        write strobe (one cycle)
//   fifo_rd        read strobe (one cycle)
//   wr_edge        one-cycle pulse per detected write press
//   rd_edge        one-cycle pulse per detected read press
//   read_more_edge one-cycle pulse per detected read-more press
//   citajVise      high for the whole duration of a read-more burst
//   rd_data_q      last word captured from the FIFO
//   rd_valid       one-cycle pulse in the cycle rd_data_q is loaded
//   burst_cnt      words read in the current or last burst
//   busy           FSM not in IDLE
// -----------------------------------------------------------------------------
module fifo_req_ctrl #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int GAP       = 1,
    parameter int DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_edge,
    input  logic              wr_btn,
    input  logic              rd_btn,
    input  logic              rm_btn,
    input  logic              fifo_full,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_we,
    output logic              fifo_rd,
    output logic              wr_edge,
    output logic              rd_edge,
    output logic              read_more_edge,
    output logic              citajVise,
    output logic [DATA_W-1:0] rd_data_q,
    output logic              rd_valid,
    output logic [3:0]        burst_cnt,
    output logic              busy
);

    localparam logic [3:0] BURST_LAST = 4'(BURST_LEN);
    // Value of the gap counter on the last idle cycle of B_GAP.
    localparam logic [3:0] GAP_LAST   = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    // Elaboration-time guard: out-of-range parameters stop the build.
    generate
        if (BURST_LEN < 1 || BURST_LEN > 15 || GAP < 0 || GAP > 15 || DB_CYCLES < 1) begin : g_bad_params
            $error("fifo_req_ctrl: parameter out of range");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input conditioning: sync -> (optional debounce) -> registered edge
    // -------------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] btn_edge;

    assign btn_raw = {rm_btn, rd_btn, wr_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            logic sync1_reg;
            logic sync2_reg;
            logic prev_reg;
            logic edge_reg;
            logic level;

            always_ff @(posedge clk) begin
                if (rst_edge) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

`ifdef FIFO_BTN_DEBOUNCE_EN
            // Counter holds 0..DB_CYCLES-1; the level flips on the cycle the
            // synchronized input has differed for DB_CYCLES cycles in a row.
            localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
            localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

            logic [DB_W-1:0] db_cnt_reg;
            logic            db_level_reg;

            always_ff @(posedge clk) begin
                if (rst_edge) begin
                    db_cnt_reg   <= '0;
                    db_level_reg <= 1'b0;
                end else if (sync2_reg != db_level_reg) begin
                    if (db_cnt_reg == DB_LAST) begin
                        db_level_reg <= sync2_reg;
                        db_cnt_reg   <= '0;
                    end else begin
                        db_cnt_reg <= db_cnt_reg + 1'b1;
                    end
                end else begin
                    // Any bounce back to the current level restarts the count.
                    db_cnt_reg <= '0;
                end
            end

            assign level = db_level_reg;
`else
            assign level = sync2_reg;
`endif

            // prev clears on reset, so a button held through reset release
            // produces exactly one edge once the synchronizer refills.
            always_ff @(posedge clk) begin
                if (rst_edge) begin
                    prev_reg <= 1'b0;
                    edge_reg <= 1'b0;
                end else begin
                    prev_reg <= level;
                    edge_reg <= level & ~prev_reg;
                end
            end

            assign btn_edge[gi] = edge_reg;
        end
    endgenerate

    assign wr_edge        = btn_edge[0];
    assign rd_edge        = btn_edge[1];
    assign read_more_edge = btn_edge[2];

    // -------------------------------------------------------------------------
    // Request FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WR     = 3'd1,
        RD     = 3'd2,
        RD_CAP = 3'd3,
        B_RD   = 3'd4,
        B_CAP  = 3'd5,
        B_GAP  = 3'd6
    } state_t;

    state_t            state_reg,     state_next;
    logic [3:0]        burst_cnt_reg, burst_cnt_next;
    logic [3:0]        gap_cnt_reg,   gap_cnt_next;
    logic [DATA_W-1:0] rd_data_reg,   rd_data_next;
    logic              citaj_reg,     citaj_next;

    always_ff @(posedge clk) begin
        if (rst_edge) begin
            state_reg     <= IDLE;
            burst_cnt_reg <= 4'd0;
            gap_cnt_reg   <= 4'd0;
            rd_data_reg   <= '0;
            citaj_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            burst_cnt_reg <= burst_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            rd_data_reg   <= rd_data_next;
            citaj_reg     <= citaj_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        gap_cnt_next   = gap_cnt_reg;
        rd_data_next   = rd_data_reg;
        citaj_next     = citaj_reg;
        fifo_we        = 1'b0;
        fifo_rd        = 1'b0;
        rd_valid       = 1'b0;

        case (state_reg)
            IDLE: begin
                // The highest-priority edge present decides; lower ones are
                // dropped even when the winner is blocked by a flag.
                if (wr_edge) begin
                    if (!fifo_full) begin
                        state_next = WR;
                    end
                end else if (rd_edge) begin
                    if (!fifo_empty) begin
                        state_next = RD;
                    end
                end else if (read_more_edge) begin
                    if (!fifo_empty) begin
                        state_next     = B_RD;
                        burst_cnt_next = 4'd0;
                        citaj_next     = 1'b1;
                    end
                end
            end

            WR: begin
                fifo_we    = 1'b1;
                state_next = IDLE;
            end

            RD: begin
                fifo_rd    = 1'b1;
                state_next = RD_CAP;
            end

            RD_CAP: begin
                rd_data_next = fifo_rd_data;
                rd_valid     = 1'b1;
                state_next   = IDLE;
            end

            B_RD: begin
                fifo_rd    = 1'b1;
                state_next = B_CAP;
            end

            B_CAP: begin
                rd_data_next   = fifo_rd_data;
                rd_valid       = 1'b1;
                burst_cnt_next = burst_cnt_reg + 4'd1;
                gap_cnt_next   = 4'd0;
                if (GAP == 0) begin
                    // No gap: end check uses the count including this word.
                    if (burst_cnt_next == BURST_LAST || fifo_empty) begin
                        citaj_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = B_RD;
                    end
                end else begin
                    state_next = B_GAP;
                end
            end

            B_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    // Empty is sampled here, so a short FIFO ends the burst early.
                    if (burst_cnt_reg == BURST_LAST || fifo_empty) begin
                        citaj_next = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = B_RD;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign citajVise = citaj_reg;
    assign rd_data_q = rd_data_reg;
    assign burst_cnt = burst_cnt_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: doc/fifo_req_ctrl.md
Name: fifo_req_ctrl

Overview:
Request side of the queue: converts raw push-button inputs (write, read, read-more) into FIFO write/read strobes. It consumes the FIFO status flags and produces the edge pulses and read-more level that the status block uses for error detection. It also sequences multi-word read-more bursts and captures read data for display.

Parameters:
DATA_W, 8, FIFO data width
BURST_LEN, 4, maximum words per read-more burst (1..15)
GAP, 1, idle cycles between burst reads (0..15)
DB_CYCLES, 16, debounce stability count (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_edge  in  1  reset: synchronous, active-high
wr_btn  in  1  raw write request (asynchronous level)
rd_btn  in  1  raw read request (asynchronous level)
rm_btn  in  1  raw read-more request (asynchronous level)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
fifo_rd_data  in  DATA_W  FIFO read data, valid 1 cycle after fifo_rd
fifo_we  out  1  write strobe, one cycle
fifo_rd  out  1  read strobe, one cycle
wr_edge  out  1  one-cycle pulse per detected write press
rd_edge  out  1  one-cycle pulse per detected read press
read_more_edge  out  1  one-cycle pulse per detected read-more press
citajVise  out  1  high for the whole duration of a read-more burst
rd_data_q  out  DATA_W  last word captured from the FIFO
rd_valid  out  1  one-cycle pulse when rd_data_q updates
burst_cnt  out  4  words read in the current or last burst
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: every flop is cleared and the FSM goes to IDLE. All outputs are 0, including rd_data_q and burst_cnt.
- Reset mid-operation: a burst or strobe in progress is abandoned. No strobe is issued in the cycle after reset.
- Input conditioning:
  - Each button passes through a 2-FF synchronizer, then a rising-edge detector (sync & ~prev).
  - The edge pulse is registered, so *_edge goes high exactly 3 clocks after the raw level is first sampled high.
  - Edge pulses are always output, whether or not the FSM accepts the request. This lets the status block flag writes-when-full and reads-when-empty.
  - A button held across reset release yields exactly one edge.
- FSM states: IDLE, WR, RD, RD_CAP, B_RD, B_CAP, B_GAP.
- IDLE transitions:
  - Priority when edges coincide: wr > rd > read-more. Lower-priority edges in the same cycle are dropped.
  - wr_edge & ~fifo_full -> WR.
  - rd_edge & ~fifo_empty -> RD.
  - read_more_edge & ~fifo_empty -> B_RD; burst_cnt cleared to 0 and citajVise set.
  - An edge whose flag blocks it (write when full, read or read-more when empty) is rejected: no strobe, stay IDLE.
- WR: fifo_we=1 for one cycle -> IDLE. fifo_we is high the cycle after wr_edge.
- RD: fifo_rd=1 -> RD_CAP.
- RD_CAP: rd_data_q <= fifo_rd_data and rd_valid=1 -> IDLE. Total latency from rd_edge to rd_valid is 2 cycles.
- B_RD: fifo_rd=1 -> B_CAP.
- B_CAP:
  - Capture the word, pulse rd_valid, burst_cnt += 1.
  - If GAP=0, go straight to the end check (below).
  - Otherwise -> B_GAP.
- B_GAP: wait GAP cycles, then do the end check.
- End check:
  - If burst_cnt == BURST_LEN or fifo_empty: clear citajVise -> IDLE.
  - Otherwise -> B_RD.
  - Empty is sampled at the check, so a burst can end early. burst_cnt holds its value until the next burst starts.
- Edges arriving while busy=1 are pulsed out but otherwise ignored (no queuing).
- fifo_we and fifo_rd are never high in the same cycle.
- fifo_rd is never issued from IDLE while fifo_empty=1.

Optional Feature:
- Macro: FIFO_BTN_DEBOUNCE_EN.
- Defined:
  - A per-button counter follows each synchronizer. The debounced level changes only after the synchronized level differs from it for DB_CYCLES consecutive cycles; any bounce restarts the count.
  - This adds DB_CYCLES cycles of latency to every *_edge. Counters clear on reset.
- Undefined: no counters; DB_CYCLES is unused; latency is as stated above.

Test Plan:
- Empty FIFO, wr_btn pulse held 5 cycles -> wr_edge 1 cycle, fifo_we 1 cycle later, busy high 1 cycle, exactly one write.
- FIFO with 2 words (0x11, 0x22), rm_btn press, BURST_LEN=4, GAP=1:
  - Two fifo_rd strobes 3 cycles apart; rd_data_q 0x11 then 0x22.
  - fifo_empty rises, burst ends with burst_cnt=2; citajVise falls.
- FIFO with 6 words, rm_btn, BURST_LEN=4 -> exactly 4 reads, burst_cnt=4, citajVise drops, 2 words remain.
- fifo_full=1, wr_btn press -> wr_edge pulses, fifo_we stays 0; with fifo_empty=1, rd_btn press -> rd_edge pulses, fifo_rd stays 0.
- wr_btn and rd_btn rise in the same cycle, FIFO half full -> fifo_we only, no fifo_rd. Then rst_edge asserted 1 cycle mid-burst -> next cycle all outputs 0 and no further fifo_rd.
- With FIFO_BTN_DEBOUNCE_EN, DB_CYCLES=16, wr_btn bounces 0/1 every 3 cycles for 30 cycles then stays high -> exactly one wr_edge, 16+3 cycles after the last transition.
